// File: rtl/minirisc_pkg.sv
// Shared MiniRISC definitions: shifter FSM state encodings, shift-mode constants and the
// default datapath width.
package minirisc_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic SH_LOGIC = 1'b0;
  localparam logic SH_ARITH = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } shift_state_t;

endpackage

// File: rtl/shift_right_step.sv
// Combinational single step of the iterative right shifter: shifts i_acc right by i_k,
// inserting sign bits for arithmetic mode and zeros for logical mode.
module shift_right_step
  import minirisc_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = 5
) (
  input  logic [WIDTH-1:0]   i_acc,
  input  logic [SHAMT_W-1:0] i_k,
  input  logic               i_fill,
  input  logic               i_mode,
  output logic [WIDTH-1:0]   o_acc
);

  logic               w_fill_bit;
  logic [2*WIDTH-1:0] w_ext;

  assign w_fill_bit = (i_mode == SH_ARITH) ? i_fill : 1'b0;
  // Fill bits sit above the operand so the shift pulls exactly i_k of them into the result.
  assign w_ext      = {{WIDTH{w_fill_bit}}, i_acc} >> i_k;
  assign o_acc      = w_ext[WIDTH-1:0];

endmodule

// File: rtl/seq_shift_right.sv
// Iterative right shifter for the MiniRISC ALU: logical or arithmetic shift by a variable
// amount, STEP bits per cycle, with a start/ready/busy/done handshake.
module seq_shift_right
  import minirisc_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out_data
);

  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  shift_state_t       r_state;
  shift_state_t       w_next_state;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_mode;
  logic               r_fill;
  logic [WIDTH-1:0]   r_out;

  logic [SHAMT_W-1:0] w_k;
  logic [SHAMT_W-1:0] w_cnt_rem;
  logic [WIDTH-1:0]   w_acc_step;

  assign w_k       = (r_cnt < STEP_AMT) ? r_cnt : STEP_AMT;
  assign w_cnt_rem = r_cnt - w_k;

  shift_right_step #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_step (
    .i_acc  (r_acc),
    .i_k    (w_k),
    .i_fill (r_fill),
    .i_mode (r_mode),
    .o_acc  (w_acc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_mode  <= SH_LOGIC;
      r_fill  <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc  <= in_data;
            r_cnt  <= shamt;
            r_mode <= arith;
            r_fill <= in_data[WIDTH-1];
            if (shamt == '0) r_out <= in_data;
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_step;
          r_cnt <= w_cnt_rem;
          // Result register is loaded only on the edge entering DONE, never mid-shift.
          if (w_cnt_rem == '0) r_out <= w_acc_step;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_next_state = (shamt == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_cnt_rem == '0) w_next_state = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign out_data = r_out;

endmodule
